// File: rtl/load_store_unit.sv
// Load/store unit: in-order issue queue, commit-gated store buffer with
// youngest-match forwarding, synchronous-read data memory, CDB slot 1 result.
module load_store_unit #(
  parameter int unsigned IQ_DEPTH = 4,
  parameter int unsigned SB_DEPTH = 4,
  parameter int unsigned MEM_AW   = 8,
  parameter logic [3:0]  LD_OP    = 4'd14,
  parameter logic [3:0]  ST_OP    = 4'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [3:0]  in_rob_idx,
  input  logic [3:0]  in_opcode,
  input  logic [15:0] in_a_value,
  input  logic [15:0] in_b_value,
  input  logic        commit_store,
  input  logic        flush,
  output logic        full,
  output logic        cdb_valid,
  output logic [3:0]  cdb_rob_idx,
  output logic [15:0] cdb_value
);
  localparam int unsigned IQ_PW     = $clog2(IQ_DEPTH);
  localparam int unsigned IQ_CW     = IQ_PW + 1;
  localparam int unsigned SB_PW     = $clog2(SB_DEPTH);
  localparam int unsigned SB_CW     = SB_PW + 1;
  localparam int unsigned MEM_WORDS = 1 << MEM_AW;

  typedef struct packed {
    logic [3:0]        rob_idx;
    logic [3:0]        opcode;
    logic [MEM_AW-1:0] addr;
    logic [15:0]       data;
  } iq_entry_t;

  // Input queue
  iq_entry_t         iq_mem_q [IQ_DEPTH];
  logic [IQ_PW-1:0]  iq_head_q, iq_head_d, iq_tail_q, iq_tail_d;
  logic [IQ_CW-1:0]  iq_count_q, iq_count_d;

  // Store buffer
  logic [MEM_AW-1:0] sb_addr_q [SB_DEPTH];
  logic [15:0]       sb_data_q [SB_DEPTH];
  logic [SB_PW-1:0]  sb_head_q, sb_head_d, sb_tail_q, sb_tail_d;
  logic [SB_CW-1:0]  sb_count_q, sb_count_d;

  // Data memory
  logic [15:0]       mem_q [MEM_WORDS];
  logic [15:0]       mem_rdata_q;

  // Issue-to-CDB stage
  logic              st_valid_q, st_valid_d;
  logic [3:0]        st_rob_q, st_rob_d;
  logic              st_use_mem_q, st_use_mem_d;
  logic [15:0]       st_data_q, st_data_d;

  logic              cdb_valid_q, cdb_valid_d;
  logic [3:0]        cdb_rob_q, cdb_rob_d;
  logic [15:0]       cdb_value_q, cdb_value_d;

  iq_entry_t         head;
  logic              head_is_ld, head_is_st, sb_full;
  logic              do_enq, do_issue, do_alloc, do_commit;
  logic              fwd_hit;
  logic [15:0]       fwd_data;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^in_a_value[15:MEM_AW];

  assign head       = iq_mem_q[iq_head_q];
  assign head_is_ld = (head.opcode == LD_OP);
  assign head_is_st = (head.opcode == ST_OP);
  assign full       = (iq_count_q == IQ_CW'(IQ_DEPTH));
  assign sb_full    = (sb_count_q == SB_CW'(SB_DEPTH));

  // Flush wins over every other action on its edge.
  assign do_enq    = in_valid && !full && !flush;
  assign do_issue  = (iq_count_q != '0) && !(head_is_st && sb_full) && !flush;
  assign do_alloc  = do_issue && head_is_st;
  assign do_commit = commit_store && (sb_count_q != '0) && !flush;

  // Scan oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < int'(SB_DEPTH); i++) begin
      if ((SB_CW'(i) < sb_count_q) &&
          (sb_addr_q[sb_head_q + SB_PW'(i)] == head.addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data_q[sb_head_q + SB_PW'(i)];
      end
    end
  end

  always_comb begin
    iq_head_d  = iq_head_q;
    iq_tail_d  = iq_tail_q;
    iq_count_d = iq_count_q;
    sb_head_d  = sb_head_q;
    sb_tail_d  = sb_tail_q;
    sb_count_d = sb_count_q;

    if (do_enq)    iq_tail_d = iq_tail_q + IQ_PW'(1);
    if (do_issue)  iq_head_d = iq_head_q + IQ_PW'(1);
    if (do_alloc)  sb_tail_d = sb_tail_q + SB_PW'(1);
    if (do_commit) sb_head_d = sb_head_q + SB_PW'(1);
    iq_count_d = iq_count_q + IQ_CW'(do_enq) - IQ_CW'(do_issue);
    sb_count_d = sb_count_q + SB_CW'(do_alloc) - SB_CW'(do_commit);

    if (flush) begin
      iq_head_d  = '0;
      iq_tail_d  = '0;
      iq_count_d = '0;
      sb_head_d  = '0;
      sb_tail_d  = '0;
      sb_count_d = '0;
    end
  end

  always_comb begin
    st_valid_d   = do_issue;
    st_rob_d     = head.rob_idx;
    st_use_mem_d = head_is_ld && !fwd_hit;
    if (head_is_st)      st_data_d = head.data;
    else if (head_is_ld) st_data_d = fwd_data;
    else                 st_data_d = '0;

    cdb_valid_d = st_valid_q && !flush;
    cdb_rob_d   = cdb_rob_q;
    cdb_value_d = cdb_value_q;
    if (cdb_valid_d) begin
      cdb_rob_d   = st_rob_q;
      cdb_value_d = st_use_mem_q ? mem_rdata_q : st_data_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iq_head_q    <= '0;
      iq_tail_q    <= '0;
      iq_count_q   <= '0;
      sb_head_q    <= '0;
      sb_tail_q    <= '0;
      sb_count_q   <= '0;
      st_valid_q   <= 1'b0;
      st_rob_q     <= '0;
      st_use_mem_q <= 1'b0;
      st_data_q    <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_rob_q    <= '0;
      cdb_value_q  <= '0;
    end else begin
      iq_head_q    <= iq_head_d;
      iq_tail_q    <= iq_tail_d;
      iq_count_q   <= iq_count_d;
      sb_head_q    <= sb_head_d;
      sb_tail_q    <= sb_tail_d;
      sb_count_q   <= sb_count_d;
      st_valid_q   <= st_valid_d;
      st_rob_q     <= st_rob_d;
      st_use_mem_q <= st_use_mem_d;
      st_data_q    <= st_data_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_rob_q    <= cdb_rob_d;
      cdb_value_q  <= cdb_value_d;
    end
  end

  // NOTE: storage arrays carry no reset; the counts and pointers above decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      iq_mem_q[iq_tail_q] <= '{rob_idx: in_rob_idx, opcode: in_opcode,
                               addr: in_a_value[MEM_AW-1:0], data: in_b_value};
    end
    if (do_alloc) begin
      sb_addr_q[sb_tail_q] <= head.addr;
      sb_data_q[sb_tail_q] <= head.data;
    end
    if (do_commit) mem_q[sb_addr_q[sb_head_q]] <= sb_data_q[sb_head_q];
    if (do_issue && head_is_ld) mem_rdata_q <= mem_q[head.addr];
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_rob_idx = cdb_rob_q;
  assign cdb_value   = cdb_value_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios with cycle checks, then random
// traffic scored against a program-order memory model.
module tb_load_store_unit;
  localparam logic [3:0] LD = 4'd14;
  localparam logic [3:0] ST = 4'd15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, commit_store, flush;
  logic [3:0]  in_rob_idx, in_opcode;
  logic [15:0] in_a_value, in_b_value;
  logic        full, cdb_valid;
  logic [3:0]  cdb_rob_idx;
  logic [15:0] cdb_value;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_rob_idx(in_rob_idx),
    .in_opcode(in_opcode), .in_a_value(in_a_value), .in_b_value(in_b_value),
    .commit_store(commit_store), .flush(flush), .full(full),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_value(cdb_value)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Directed-phase result recorder
  bit          rec_en = 1'b1;
  logic [19:0] log_q[$];
  always @(negedge clk) if (rec_en && cdb_valid) log_q.push_back({cdb_rob_idx, cdb_value});

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; commit_store = 0; flush = 0;
    in_rob_idx = 0; in_opcode = 0; in_a_value = 0; in_b_value = 0;
  endtask

  task automatic enq(input logic [3:0] rob, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    in_valid = 1; in_rob_idx = rob; in_opcode = op; in_a_value = a; in_b_value = b;
    step();
    in_valid = 0;
  endtask

  task automatic pulse_commit();
    commit_store = 1;
    step();
    commit_store = 0;
  endtask

  task automatic pulse_flush();
    flush = 1;
    step();
    flush = 0;
  endtask

  task automatic expect_log(input string tag, input logic [3:0] rob, input logic [15:0] val);
    logic [19:0] e;
    int k = 0;
    while (log_q.size() == 0 && k < 12) begin step(); k++; end
    check({tag, "_seen"}, 32'(log_q.size() != 0), 32'd1);
    if (log_q.size() != 0) begin
      e = log_q.pop_front();
      check({tag, "_rob"}, 32'(e[19:16]), 32'(rob));
      check({tag, "_val"}, 32'(e[15:0]), 32'(val));
    end
  endtask

  task automatic expect_quiet(input string tag, input int n);
    repeat (n) step();
    check(tag, 32'(log_q.size()), 32'd0);
    log_q.delete();
  endtask

  task automatic store_commit(input logic [3:0] rob, input logic [15:0] a, input logic [15:0] b);
    enq(rob, ST, a, b);
    expect_log("pre_st", rob, b);
    pulse_commit();
  endtask

  // Reference model: program-order view of memory over an 8-word window
  typedef struct { logic [3:0] rob; logic [15:0] val; bit is_st; } res_t;
  typedef struct { int idx; logic [15:0] d; } st_t;
  logic [15:0] cmem [8];
  logic [15:0] amem [8];
  res_t        expq[$];
  st_t         pend[$];
  int          issued_unc = 0;

  task automatic observe();
    res_t e;
    if (cdb_valid) begin
      if (expq.size() == 0) check("rnd_spurious", 32'(cdb_valid), 32'd0);
      else begin
        e = expq.pop_front();
        check("rnd_rob", 32'(cdb_rob_idx), 32'(e.rob));
        check("rnd_val", 32'(cdb_value), 32'(e.val));
        if (e.is_st) issued_unc++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rob_ctr;
    logic [15:0] v;
    idle();
    step(); step();
    check("rst_full", 32'(full), 32'd0);
    check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    check("rst_cdb_rob", 32'(cdb_rob_idx), 32'd0);
    check("rst_cdb_value", 32'(cdb_value), 32'd0);
    rst_n = 1;
    step();

    // 1: plain load latency, address upper bits ignored, unknown opcode
    store_commit(4'd0, 16'h0010, 16'h1234);
    store_commit(4'd1, 16'h0020, 16'h5A5A);
    log_q.delete();
    enq(4'd3, LD, 16'h0010, 16'h0000);
    step();
    check("t1_not_yet", 32'(cdb_valid), 32'd0);
    step();
    check("t1_valid", 32'(cdb_valid), 32'd1);
    check("t1_rob", 32'(cdb_rob_idx), 32'd3);
    check("t1_value", 32'(cdb_value), 32'h1234);
    step();
    check("t1_pulse", 32'(cdb_valid), 32'd0);
    check("t1_hold_rob", 32'(cdb_rob_idx), 32'd3);
    check("t1_hold_val", 32'(cdb_value), 32'h1234);
    log_q.delete();
    enq(4'd4, LD, 16'hAB10, 16'h0000);
    expect_log("t1_hi_addr", 4'd4, 16'h1234);
    enq(4'd7, 4'd3, 16'h0010, 16'hFFFF);
    expect_log("t1_unknown", 4'd7, 16'h0000);

    // 2: store then load forwards; memory untouched until commit
    enq(4'd1, ST, 16'h0020, 16'hBEEF);
    enq(4'd2, LD, 16'h0020, 16'h0000);
    expect_log("t2_st", 4'd1, 16'hBEEF);
    expect_log("t2_ld", 4'd2, 16'hBEEF);
    pulse_flush();
    enq(4'd4, LD, 16'h0020, 16'h0000);
    expect_log("t2_mem", 4'd4, 16'h5A5A);

    // 3: SB full stalls the 5th store and the load behind it
    for (int i = 0; i < 4; i++) enq(4'(5 + i), ST, 16'h0050 + 16'(i), 16'hA000 + 16'(i));
    enq(4'd10, ST, 16'h0054, 16'hA004);
    enq(4'd11, LD, 16'h0054, 16'h0000);
    for (int i = 0; i < 4; i++) expect_log("t3_fill", 4'(5 + i), 16'hA000 + 16'(i));
    expect_quiet("t3_stall", 4);
    check("t3_full", 32'(full), 32'd0);
    pulse_commit();
    step();
    check("t3_c1", 32'(cdb_valid), 32'd0);
    expect_log("t3_st5", 4'd10, 16'hA004);
    expect_log("t3_ld", 4'd11, 16'hA004);

    // 4: IQ fills behind a full SB; in_valid while full is dropped
    for (int i = 0; i < 4; i++) enq(4'(12 + i), ST, 16'h0060 + 16'(i), 16'hC000 + 16'(i));
    check("t4_full", 32'(full), 32'd1);
    enq(4'd9, LD, 16'h0050, 16'h0000);
    check("t4_full_hold", 32'(full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      pulse_commit();
      expect_log("t4_drain", 4'(12 + i), 16'hC000 + 16'(i));
    end
    repeat (4) pulse_commit();
    expect_quiet("t4_no_rob9", 6);
    check("t4_full_clr", 32'(full), 32'd0);
    enq(4'd1, LD, 16'h0050, 16'h0000);
    expect_log("t4_m50", 4'd1, 16'hA000);
    enq(4'd2, LD, 16'h0054, 16'h0000);
    expect_log("t4_m54", 4'd2, 16'hA004);
    enq(4'd3, LD, 16'h0063, 16'h0000);
    expect_log("t4_m63", 4'd3, 16'hC003);

    // 5: youngest match wins; same-edge commit still forwards
    enq(4'd1, ST, 16'h0030, 16'h1111);
    enq(4'd2, ST, 16'h0030, 16'h2222);
    enq(4'd3, LD, 16'h0030, 16'h0000);
    expect_log("t5_st1", 4'd1, 16'h1111);
    expect_log("t5_st2", 4'd2, 16'h2222);
    expect_log("t5_ld", 4'd3, 16'h2222);
    pulse_commit();
    pulse_commit();
    enq(4'd4, LD, 16'h0030, 16'h0000);
    expect_log("t5_mem", 4'd4, 16'h2222);
    enq(4'd5, ST, 16'h0031, 16'h7777);
    expect_log("t5_st31", 4'd5, 16'h7777);
    enq(4'd6, LD, 16'h0031, 16'h0000);
    pulse_commit();
    expect_log("t5_same_edge", 4'd6, 16'h7777);
    enq(4'd7, LD, 16'h0031, 16'h0000);
    expect_log("t5_mem31", 4'd7, 16'h7777);

    // 6a: asynchronous reset mid-operation
    enq(4'd8, LD, 16'h0030, 16'h0000);
    enq(4'd9, LD, 16'h0030, 16'h0000);
    #1 rst_n = 0;
    #1;
    check("t6_rst_valid", 32'(cdb_valid), 32'd0);
    check("t6_rst_full", 32'(full), 32'd0);
    check("t6_rst_rob", 32'(cdb_rob_idx), 32'd0);
    check("t6_rst_val", 32'(cdb_value), 32'd0);
    step();
    rst_n = 1;
    expect_quiet("t6_rst_quiet", 5);
    enq(4'd9, LD, 16'h0030, 16'h0000);
    expect_log("t6_mem_kept", 4'd9, 16'h2222);

    // 6b: flush with queued entries, with a same-edge enqueue, and in flight
    for (int i = 0; i < 4; i++) enq(4'(1 + i), ST, 16'h0030, 16'hDEA0 + 16'(i));
    for (int i = 0; i < 4; i++) expect_log("t6_fill", 4'(1 + i), 16'hDEA0 + 16'(i));
    enq(4'd5, ST, 16'h0035, 16'h5555);
    enq(4'd6, LD, 16'h0030, 16'h0000);
    expect_quiet("t6_stall", 2);
    check("t6_full_pre", 32'(full), 32'd0);
    in_valid = 1; in_rob_idx = 4'd12; in_opcode = LD; in_a_value = 16'h0030;
    commit_store = 1;
    pulse_flush();
    idle();
    expect_quiet("t6_flush_quiet", 5);
    check("t6_full_post", 32'(full), 32'd0);
    enq(4'd7, LD, 16'h0030, 16'h0000);
    expect_log("t6_sb_clear", 4'd7, 16'h2222);
    enq(4'd8, LD, 16'h0030, 16'h0000);
    step();
    pulse_flush();
    check("t6_inflight", 32'(cdb_valid), 32'd0);
    expect_quiet("t6_inflight_quiet", 3);

    // Random traffic over addresses 0x40..0x47
    for (int i = 0; i < 8; i++) begin
      v = 16'($urandom);
      store_commit(4'(i), 16'h0040 + 16'(i), v);
      cmem[i] = v;
      amem[i] = v;
    end
    rec_en = 0;
    log_q.delete();
    rob_ctr = 0;
    for (int it = 0; it < 2000; it++) begin
      step();
      observe();
      idle();
      if ($urandom_range(0, 59) == 0) begin
        flush = 1;
        expq.delete();
        pend.delete();
        issued_unc = 0;
        amem = cmem;
      end else begin
        if (issued_unc > 0 && $urandom_range(0, 2) == 0) begin
          st_t s;
          commit_store = 1;
          s = pend.pop_front();
          cmem[s.idx] = s.d;
          issued_unc--;
        end
        if ($urandom_range(0, 1) == 1) begin
          int idx, r;
          res_t e;
          idx = $urandom_range(0, 7);
          r = $urandom_range(0, 9);
          in_valid   = 1;
          in_rob_idx = rob_ctr;
          in_opcode  = (r < 4) ? LD : (r < 9) ? ST : 4'($urandom_range(0, 13));
          in_a_value = {8'($urandom), 8'(8'h40 + idx)};
          in_b_value = 16'($urandom);
          if (!full) begin
            e.rob = rob_ctr;
            e.is_st = (in_opcode == ST);
            if (in_opcode == LD) e.val = amem[idx];
            else if (in_opcode == ST) begin
              e.val = in_b_value;
              amem[idx] = in_b_value;
              pend.push_back('{idx: idx, d: in_b_value});
            end else e.val = 16'h0000;
            expq.push_back(e);
            rob_ctr++;
          end
        end
      end
    end
    for (int k = 0; k < 400 && (expq.size() != 0 || pend.size() != 0); k++) begin
      step();
      observe();
      idle();
      if (issued_unc > 0) begin
        st_t s;
        commit_store = 1;
        s = pend.pop_front();
        cmem[s.idx] = s.d;
        issued_unc--;
      end
    end
    step();
    idle();
    check("rnd_drain", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
